// File: rtl/inv_mix_col_iter.sv
`default_nettype none
// ============================================================================
// Module   : inv_mix_col_iter
// Purpose  : Iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock,
//            valid/ready on both sides with a registered, holdable result.
// Revision : 1.0 - initial release
// ============================================================================
module inv_mix_col_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int c_GROUPS = 4 / COLS_PER_CYCLE;
    localparam int c_CNT_W  = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the result mixes b_k, b_(k-1), b_(k-2), b_(k-3) with 0e/0b/0d/09.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0]  b, x2, x4, x8;
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [31:0] res;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            b     = col[8*j +: 8];
            x2    = xtime(b);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[j] = x8 ^ b;
            mb[j] = x8 ^ x2 ^ b;
            md[j] = x8 ^ x4 ^ b;
            me[j] = x8 ^ x4 ^ x2;
        end
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = me[k] ^ mb[(k + 3) % 4] ^ md[(k + 2) % 4] ^ m9[(k + 1) % 4];
        end
        return res;
    endfunction

    logic [1:0]         r_state;
    logic [127:0]       r_work;
    logic [c_CNT_W-1:0] r_cnt;
    logic [127:0]       w_next_work;
    logic               w_last;

    assign w_last    = (r_cnt == c_CNT_W'(c_GROUPS - 1));
    assign in_ready  = (r_state == c_IDLE) | ((r_state == c_DONE) & out_ready);
    assign out_valid = (r_state == c_DONE);
    assign out_data  = r_work;

    always_comb begin
        w_next_work = r_work;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            w_next_work[(int'(r_cnt) * COLS_PER_CYCLE + g) * 32 +: 32] =
                inv_col(r_work[(int'(r_cnt) * COLS_PER_CYCLE + g) * 32 +: 32]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data;
                        r_cnt   <= '0;
                        r_state <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    r_work <= w_next_work;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_DONE: begin
                    // Handoff and the next accept share one edge: no bubble.
                    if (out_ready) begin
                        if (in_valid) begin
                            r_work  <= in_data;
                            r_cnt   <= '0;
                            r_state <= c_BUSY;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
